// File: rtl/note_sequencer.sv
// note_sequencer: tempo-driven melody sequencer walking a note ROM.
// Each ROM word carries a 5-bit note code [7:3] and a 3-bit duration [2:0]
// (duration+1 ticks). Code 31 ends the song; codes 22..30 play as rest.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   start, stop    - one-cycle control pulses (stop has priority)
//   pause          - level; freezes counters and silences note while playing
//   loop_en        - restart from address 0 on the end marker
//   rom_addr       - registered ROM read address
//   rom_data       - ROM word, valid one cycle after rom_addr
//   note           - registered note code to the divider stage (0 = rest)
//   playing        - high in every state except IDLE
//   done           - one-cycle pulse on natural end of song
module note_sequencer #(
  parameter int unsigned TICK_CYCLES = 12_500_000,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [4:0]        note,
  output logic              playing,
  output logic              done
);

  localparam int unsigned       TICK_W    = $clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [4:0]        END_CODE  = 5'd31;
  localparam logic [4:0]        MAX_PITCH = 5'd21;

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, PLAY} state_t;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        dur_cnt;
  logic [4:0]        code;

  logic [4:0] rom_code;
  logic [2:0] rom_dur;
  logic [4:0] play_code;

  // Field split of the ROM word; out-of-range pitches become rests
  assign rom_code  = rom_data[7:3];
  assign rom_dur   = rom_data[2:0];
  assign play_code = (rom_code > MAX_PITCH) ? 5'd0 : rom_code;

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      note     <= 5'd0;
      playing  <= 1'b0;
      done     <= 1'b0;
      tick_cnt <= '0;
      dur_cnt  <= 3'd0;
      code     <= 5'd0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        rom_addr <= '0;
        note     <= 5'd0;
        playing  <= 1'b0;
      end else if (start) begin
        // Restart from the top; note holds until the first entry is latched
        state    <= FETCH;
        rom_addr <= '0;
        playing  <= 1'b1;
      end else begin
        case (state)
          IDLE:  state <= IDLE;
          FETCH: state <= LATCH;
          LATCH: begin
            if (rom_code == END_CODE) begin
              if (loop_en) begin
                rom_addr <= '0;
                state    <= FETCH;
              end else begin
                done    <= 1'b1;
                note    <= 5'd0;
                playing <= 1'b0;
                state   <= IDLE;
              end
            end else begin
              code     <= play_code;
              note     <= play_code;
              dur_cnt  <= rom_dur;
              tick_cnt <= '0;
              state    <= PLAY;
            end
          end
          PLAY: begin
            // Pause silences the output and freezes both counters
            if (pause) begin
              note <= 5'd0;
            end else begin
              note <= code;
              if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (dur_cnt == 3'd0) begin
                  rom_addr <= rom_addr + ADDR_W'(1);
                  state    <= FETCH;
                end else begin
                  dur_cnt <= dur_cnt - 3'd1;
                end
              end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer: directed scenarios with a segment scoreboard.
// The monitor splits the output stream into runs of constant
// {note, playing, done} and checks each run's value and length against
// the queued expectations.
module tb_note_sequencer;

  localparam int unsigned TICK = 4;
  localparam int unsigned AW   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          pause;
  logic          loop_en;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [4:0]    note;
  logic          playing;
  logic          done;

  logic [7:0] rom [64];

  note_sequencer #(.TICK_CYCLES(TICK), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .loop_en  (loop_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .note     (note),
    .playing  (playing),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [4:0] note;
    logic       playing;
    logic       done;
    int         len;   // 0 = length not checked
  } seg_t;

  seg_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  int   seg_idx  = 0;

  logic [6:0] prev_s;
  logic [6:0] cur_s;
  int         run_len;
  bit         have = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  function automatic void exp_seg(logic [4:0] n, logic p, logic d, int len);
    seg_t e;
    e.note = n; e.playing = p; e.done = d; e.len = len;
    exp_q.push_back(e);
  endfunction

  function automatic void close_seg();
    seg_t e;
    seg_idx++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL seg%0d_unexpected: got note=%0d playing=%0d done=%0d len=%0d, required no segment",
               seg_idx, prev_s[6:2], prev_s[1], prev_s[0], run_len);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("seg%0d_value{note,playing,done}", seg_idx),
            32'(prev_s), 32'({e.note, e.playing, e.done}));
      if (e.len != 0)
        check($sformatf("seg%0d_len", seg_idx), 32'(run_len), 32'(e.len));
    end
  endfunction

  // Monitor: close a run whenever the sampled output tuple changes
  always @(negedge clk) begin
    if (!mon_en) begin
      have = 1'b0;
    end else begin
      cur_s = {note, playing, done};
      if (!have) begin
        have    = 1'b1;
        prev_s  = cur_s;
        run_len = 1;
      end else if (cur_s === prev_s) begin
        run_len++;
      end else begin
        close_seg();
        prev_s  = cur_s;
        run_len = 1;
      end
    end
  end

  function automatic logic [7:0] ent(logic [4:0] c, logic [2:0] d);
    return {c, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 64; i++) rom[i] = 8'hFF;
    rom[0] = ent(5'd17, 3'd1);
    rom[1] = ent(5'd14, 3'd0);
    rom[2] = ent(5'd31, 3'd0);
  endtask

  task automatic begin_scn();
    seg_idx = 0;
    mon_en  = 1'b1;
    tick();
  endtask

  task automatic wait_q(int unsigned lim, int budget, string name);
    int b = budget;
    while (exp_q.size() > lim && b > 0) begin
      tick();
      b--;
    end
    if (exp_q.size() > lim) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d segments pending, required <= %0d", name, exp_q.size(), lim);
      exp_q.delete();
    end
  endtask

  task automatic drain(int budget, string name);
    wait_q(0, budget, name);
    mon_en = 1'b0;
    tick();
  endtask

  initial begin
    logic [AW-1:0] prev_addr;
    bit            wrapped;

    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    load_basic();
    tick();
    tick();
    check("reset_note", 32'(note), 32'd0);
    check("reset_playing", 32'(playing), 32'd0);
    check("reset_addr", 32'(rom_addr), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Basic song: 17 (2 ticks), 14 (1 tick), end marker
    begin_scn();
    exp_seg(5'd0, 1'b0, 1'b0, 0);
    exp_seg(5'd0, 1'b1, 1'b0, 2);
    exp_seg(5'd17, 1'b1, 1'b0, 10);
    exp_seg(5'd14, 1'b1, 1'b0, 6);
    exp_seg(5'd0, 1'b0, 1'b1, 1);
    pulse_start();
    drain(100, "basic");

    // Looping: 17,14,17,14 with no done pulse, then stop
    loop_en = 1'b1;
    begin_scn();
    exp_seg(5'd0, 1'b0, 1'b0, 0);
    exp_seg(5'd0, 1'b1, 1'b0, 2);
    exp_seg(5'd17, 1'b1, 1'b0, 10);
    exp_seg(5'd14, 1'b1, 1'b0, 8);
    exp_seg(5'd17, 1'b1, 1'b0, 10);
    exp_seg(5'd14, 1'b1, 1'b0, 0);
    pulse_start();
    wait_q(1, 200, "loop");
    pulse_stop();
    drain(50, "loop_stop");
    loop_en = 1'b0;

    // Pause 10 cycles inside the 17 note
    begin_scn();
    exp_seg(5'd0, 1'b0, 1'b0, 0);
    exp_seg(5'd0, 1'b1, 1'b0, 2);
    exp_seg(5'd17, 1'b1, 1'b0, 3);
    exp_seg(5'd0, 1'b1, 1'b0, 10);
    exp_seg(5'd17, 1'b1, 1'b0, 7);
    exp_seg(5'd14, 1'b1, 1'b0, 6);
    exp_seg(5'd0, 1'b0, 1'b1, 1);
    pulse_start();
    repeat (4) tick();
    pause = 1'b1;
    repeat (10) tick();
    pause = 1'b0;
    drain(100, "pause");

    // start+stop together during the 14 note: stop wins
    begin_scn();
    exp_seg(5'd0, 1'b0, 1'b0, 0);
    exp_seg(5'd0, 1'b1, 1'b0, 2);
    exp_seg(5'd17, 1'b1, 1'b0, 10);
    exp_seg(5'd14, 1'b1, 1'b0, 2);
    pulse_start();
    repeat (13) tick();
    check("collide_addr_before", 32'(rom_addr), 32'd1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("collide_addr", 32'(rom_addr), 32'd0);
    check("collide_note", 32'(note), 32'd0);
    check("collide_playing", 32'(playing), 32'd0);
    check("collide_done", 32'(done), 32'd0);
    drain(20, "collide");

    // start alone during the 14 note restarts from address 0
    begin_scn();
    exp_seg(5'd0, 1'b0, 1'b0, 0);
    exp_seg(5'd0, 1'b1, 1'b0, 2);
    exp_seg(5'd17, 1'b1, 1'b0, 10);
    exp_seg(5'd14, 1'b1, 1'b0, 4);
    exp_seg(5'd17, 1'b1, 1'b0, 10);
    exp_seg(5'd14, 1'b1, 1'b0, 6);
    exp_seg(5'd0, 1'b0, 1'b1, 1);
    pulse_start();
    repeat (13) tick();
    check("restart_addr_before", 32'(rom_addr), 32'd1);
    pulse_start();
    check("restart_addr", 32'(rom_addr), 32'd0);
    check("restart_playing", 32'(playing), 32'd1);
    drain(100, "restart");

    // Code 25 plays as a rest for 4 cycles
    for (int i = 0; i < 64; i++) rom[i] = 8'hFF;
    rom[0] = ent(5'd25, 3'd0);
    begin_scn();
    exp_seg(5'd0, 1'b0, 1'b0, 0);
    exp_seg(5'd0, 1'b1, 1'b0, 8);
    exp_seg(5'd0, 1'b0, 1'b1, 1);
    pulse_start();
    drain(50, "rest_code");

    // Reset mid-playback
    load_basic();
    pulse_start();
    repeat (13) tick();
    check("midreset_note_before", 32'(note), 32'd14);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("midreset_note", 32'(note), 32'd0);
    check("midreset_playing", 32'(playing), 32'd0);
    check("midreset_addr", 32'(rom_addr), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    tick();
    check("midreset_stays_idle", 32'(playing), 32'd0);

    // No end marker: address wraps 63 -> 0 and playback continues
    for (int i = 0; i < 64; i++) rom[i] = ent(5'd1, 3'd0);
    pulse_start();
    prev_addr = rom_addr;
    wrapped   = 1'b0;
    for (int b = 0; b < 800 && !wrapped; b++) begin
      tick();
      if (prev_addr == AW'(63) && rom_addr != AW'(63)) begin
        wrapped = 1'b1;
        check("wrap_addr", 32'(rom_addr), 32'd0);
        check("wrap_playing", 32'(playing), 32'd1);
      end
      prev_addr = rom_addr;
    end
    if (!wrapped) begin
      n_checks++;
      n_fail++;
      $display("FAIL wrap_timeout: got addr %0d, required a 63->0 wrap", rom_addr);
    end
    pulse_stop();
    check("wrap_stop_playing", 32'(playing), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
